// File: rtl/pulpemu_gpio_pkg.sv
// Shared types and defaults for the PULP/PS GPIO pad arbiter.
// State literals carry an ST_ prefix so they do not collide with the owner_e literals.
package pulpemu_gpio_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_PULP = 2'b01,
    OWN_PS   = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN_PULP,
    ST_OWN_PS,
    ST_TURN
  } arb_state_e;

  localparam int unsigned DEFAULT_NUM_GPIO      = 8;
  localparam int unsigned DEFAULT_TURN_CYCLES   = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
  localparam int unsigned DEFAULT_FILTER_CYCLES = 4;
  localparam int unsigned TURN_CNT_W            = 8;

  function automatic owner_e state_owner(input arb_state_e s);
    case (s)
      ST_OWN_PULP: return OWN_PULP;
      ST_OWN_PS:   return OWN_PS;
      default:     return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pulpemu_gpio_insync.sv
// One pad input bit: multi-flop synchroniser plus an optional stability filter.
// Filter is built only when PULPEMU_GPIO_GLITCH_FILTER_EN is defined.
module pulpemu_gpio_insync #(
  parameter int unsigned SYNC_STAGES   = pulpemu_gpio_pkg::DEFAULT_SYNC_STAGES,
  parameter int unsigned FILTER_CYCLES = pulpemu_gpio_pkg::DEFAULT_FILTER_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pulpemu_gpio_insync: SYNC_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("pulpemu_gpio_insync: FILTER_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

`ifdef PULPEMU_GPIO_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Any cycle where the synced value agrees with the output restarts the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        filt_d = sync_q[SYNC_STAGES-1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign sync_o = filt_q;
`else
  assign sync_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pulpemu_gpio_arbiter.sv
// Shares the FMC GPIO pads between PULP SoC GPIO and Zynq PS EMIO GPIO with a forced turnaround.
// Optional input glitch filter: define PULPEMU_GPIO_GLITCH_FILTER_EN.
module pulpemu_gpio_arbiter
  import pulpemu_gpio_pkg::*;
#(
  parameter int unsigned NUM_GPIO      = DEFAULT_NUM_GPIO,
  parameter int unsigned TURN_CYCLES   = DEFAULT_TURN_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int unsigned FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pulp_req_i,
  output logic                pulp_gnt_o,
  input  logic [NUM_GPIO-1:0] pulp_gpio_out_i,
  input  logic [NUM_GPIO-1:0] pulp_gpio_dir_i,
  output logic [NUM_GPIO-1:0] pulp_gpio_in_o,
  input  logic                ps_req_i,
  output logic                ps_gnt_o,
  input  logic [NUM_GPIO-1:0] ps_gpio_out_i,
  input  logic [NUM_GPIO-1:0] ps_gpio_dir_i,
  output logic [NUM_GPIO-1:0] ps_gpio_in_o,
  output logic [NUM_GPIO-1:0] pad_out_o,
  output logic [NUM_GPIO-1:0] pad_dir_o,
  input  logic [NUM_GPIO-1:0] pad_in_i,
  output owner_e              owner_o
);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 255) begin : g_bad_turn
    $error("pulpemu_gpio_arbiter: TURN_CYCLES must be in 1..255");
  end

  arb_state_e              state_q;
  owner_e                  last_q;
  logic [TURN_CNT_W-1:0]   cnt_q;
  logic [NUM_GPIO-1:0]     pad_out_q;
  logic [NUM_GPIO-1:0]     pad_dir_q;
  logic [NUM_GPIO-1:0]     pad_in_sync;

  // Pads follow the registered state, so the first granted cycle is still tristated.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      last_q    <= OWN_PS;
      cnt_q     <= '0;
      pad_out_q <= '0;
      pad_dir_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pulp_req_i && ps_req_i) begin
            state_q <= (last_q == OWN_PULP) ? ST_OWN_PS : ST_OWN_PULP;
          end else if (pulp_req_i) begin
            state_q <= ST_OWN_PULP;
          end else if (ps_req_i) begin
            state_q <= ST_OWN_PS;
          end
        end
        ST_OWN_PULP: begin
          if (!pulp_req_i) begin
            state_q <= ST_TURN;
            cnt_q   <= TURN_CNT_W'(TURN_CYCLES - 1);
            last_q  <= OWN_PULP;
          end
        end
        ST_OWN_PS: begin
          if (!ps_req_i) begin
            state_q <= ST_TURN;
            cnt_q   <= TURN_CNT_W'(TURN_CYCLES - 1);
            last_q  <= OWN_PS;
          end
        end
        ST_TURN: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      unique case (state_q)
        ST_OWN_PULP: begin
          pad_out_q <= pulp_gpio_out_i;
          pad_dir_q <= pulp_gpio_dir_i;
        end
        ST_OWN_PS: begin
          pad_out_q <= ps_gpio_out_i;
          pad_dir_q <= ps_gpio_dir_i;
        end
        default: begin
          pad_out_q <= '0;
          pad_dir_q <= '0;
        end
      endcase
    end
  end

  assign pulp_gnt_o = (state_q == ST_OWN_PULP);
  assign ps_gnt_o   = (state_q == ST_OWN_PS);
  assign owner_o    = state_owner(state_q);
  assign pad_out_o  = pad_out_q;
  assign pad_dir_o  = pad_dir_q;

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_insync
    pulpemu_gpio_insync #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_insync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .async_i(pad_in_i[g]),
      .sync_o (pad_in_sync[g])
    );
  end

  assign pulp_gpio_in_o = pad_in_sync;
  assign ps_gpio_in_o   = pad_in_sync;

endmodule

// File: tb/tb_pulpemu_gpio_arbiter.sv
// Self-checking bench for pulpemu_gpio_arbiter: directed vector table, hand sequences, randomized model check.
// Honours PULPEMU_GPIO_GLITCH_FILTER_EN for the expected input-path latency.
module tb_pulpemu_gpio_arbiter;
  import pulpemu_gpio_pkg::*;

  localparam int NUM_GPIO      = 8;
  localparam int TURN_CYCLES   = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int FILTER_CYCLES = 4;
`ifdef PULPEMU_GPIO_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif
  localparam int IN_LATENCY = SYNC_STAGES + (FILTER_ON ? FILTER_CYCLES : 0);

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       pulp_req_i, ps_req_i;
  logic [7:0] pulp_gpio_out_i, pulp_gpio_dir_i, ps_gpio_out_i, ps_gpio_dir_i, pad_in_i;
  logic       pulp_gnt_o, ps_gnt_o;
  logic [7:0] pulp_gpio_in_o, ps_gpio_in_o, pad_out_o, pad_dir_o;
  logic [1:0] owner_o;

  int checks = 0;
  int errors = 0;

  pulpemu_gpio_arbiter #(
    .NUM_GPIO(NUM_GPIO), .TURN_CYCLES(TURN_CYCLES),
    .SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pulp_req_i(pulp_req_i), .pulp_gnt_o(pulp_gnt_o),
    .pulp_gpio_out_i(pulp_gpio_out_i), .pulp_gpio_dir_i(pulp_gpio_dir_i), .pulp_gpio_in_o(pulp_gpio_in_o),
    .ps_req_i(ps_req_i), .ps_gnt_o(ps_gnt_o),
    .ps_gpio_out_i(ps_gpio_out_i), .ps_gpio_dir_i(ps_gpio_dir_i), .ps_gpio_in_o(ps_gpio_in_o),
    .pad_out_o(pad_out_o), .pad_dir_o(pad_dir_o), .pad_in_i(pad_in_i),
    .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       pReq;
    logic       sReq;
    logic       expPulpGnt;
    logic       expPsGnt;
    logic [1:0] padSel;   // 0 tristated, 1 PULP values, 2 PS values
    logic [1:0] expOwner;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: who owns the pads, how many blocked cycles remain, input history.
  int         mOwner, mLast, mBlock;
  logic [7:0] mPadOut, mPadDir, mFilt;
  logic [7:0] mHist[SYNC_STAGES];
  int         mRun[NUM_GPIO];

  task automatic applyStimulus(input logic rst, input logic pReq, input logic sReq,
                               input logic [7:0] pOut, input logic [7:0] pDir,
                               input logic [7:0] sOut, input logic [7:0] sDir,
                               input logic [7:0] padIn);
    rst_ni          = rst;
    pulp_req_i      = pReq;
    ps_req_i        = sReq;
    pulp_gpio_out_i = pOut;
    pulp_gpio_dir_i = pDir;
    ps_gpio_out_i   = sOut;
    ps_gpio_dir_i   = sDir;
    pad_in_i        = padIn;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic p, input logic s, input logic pg, input logic sg,
                              input logic [1:0] sel, input logic [1:0] own);
    vec_t v;
    v.pReq = p; v.sReq = s; v.expPulpGnt = pg; v.expPsGnt = sg; v.padSel = sel; v.expOwner = own;
    return v;
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    logic [7:0] syncPrev;
    logic       ownerReq;
    if (!rst_ni) begin
      mOwner = 0; mLast = 2; mBlock = 0;
      mPadOut = '0; mPadDir = '0; mFilt = '0;
      for (int s = 0; s < SYNC_STAGES; s++) mHist[s] = '0;
      for (int b = 0; b < NUM_GPIO; b++) mRun[b] = 0;
    end else begin
      mPadOut = (mOwner == 1) ? pulp_gpio_out_i : (mOwner == 2) ? ps_gpio_out_i : 8'h00;
      mPadDir = (mOwner == 1) ? pulp_gpio_dir_i : (mOwner == 2) ? ps_gpio_dir_i : 8'h00;
      syncPrev = mHist[SYNC_STAGES-1];
      for (int b = 0; b < NUM_GPIO; b++) begin
        if (syncPrev[b] != mFilt[b]) begin
          mRun[b]++;
          if (mRun[b] == FILTER_CYCLES) begin
            mFilt[b] = syncPrev[b];
            mRun[b]  = 0;
          end
        end else begin
          mRun[b] = 0;
        end
      end
      for (int s = SYNC_STAGES - 1; s > 0; s--) mHist[s] = mHist[s-1];
      mHist[0] = pad_in_i;
      ownerReq = (mOwner == 1) ? pulp_req_i : ps_req_i;
      if (mOwner != 0) begin
        if (!ownerReq) begin
          mLast  = mOwner;
          mOwner = 0;
          mBlock = TURN_CYCLES;
        end
      end else if (mBlock > 0) begin
        mBlock--;
      end else if (pulp_req_i && ps_req_i) begin
        mOwner = (mLast == 1) ? 2 : 1;
      end else if (pulp_req_i) begin
        mOwner = 1;
      end else if (ps_req_i) begin
        mOwner = 2;
      end
    end
  endtask

  initial begin
    logic [7:0] expOut, expDir, expIn;
    logic       rReq, sReqR, rRst;
    logic [7:0] rPad;
    int         highCount;

    // Directed table, starting right after reset (last owner = PS).
    vecs.push_back(mk(1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 2));
    vecs.push_back(mk(1, 1, 0, 1, 2, 2));
    vecs.push_back(mk(1, 0, 0, 0, 2, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 1, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1));

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      checkOutput($sformatf("reset%0d pulp_gnt", i), pulp_gnt_o, 0);
      checkOutput($sformatf("reset%0d ps_gnt", i), ps_gnt_o, 0);
      checkOutput($sformatf("reset%0d pad_dir", i), pad_dir_o, 0);
      checkOutput($sformatf("reset%0d pad_out", i), pad_out_o, 0);
      checkOutput($sformatf("reset%0d owner", i), owner_o, 0);
      checkOutput($sformatf("reset%0d pulp_in", i), pulp_gpio_in_o, 0);
      checkOutput($sformatf("reset%0d ps_in", i), ps_gpio_in_o, 0);
    end

    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].pReq, vecs[i].sReq, 8'hA5, 8'h0F, 8'h5A, 8'hF0, 8'h00);
      tick();
      expOut = (vecs[i].padSel == 1) ? 8'hA5 : (vecs[i].padSel == 2) ? 8'h5A : 8'h00;
      expDir = (vecs[i].padSel == 1) ? 8'h0F : (vecs[i].padSel == 2) ? 8'hF0 : 8'h00;
      checkOutput($sformatf("vec%0d pulp_gnt", i), pulp_gnt_o, vecs[i].expPulpGnt);
      checkOutput($sformatf("vec%0d ps_gnt", i), ps_gnt_o, vecs[i].expPsGnt);
      checkOutput($sformatf("vec%0d pad_out", i), pad_out_o, expOut);
      checkOutput($sformatf("vec%0d pad_dir", i), pad_dir_o, expDir);
      checkOutput($sformatf("vec%0d owner", i), owner_o, vecs[i].expOwner);
    end

    // Input synchroniser latency.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
    end
    checkOutput("sync idle pulp_in", pulp_gpio_in_o, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C);
    for (int i = 1; i < IN_LATENCY; i++) tick();
    checkOutput("sync early pulp_in", pulp_gpio_in_o, 8'h00);
    tick();
    checkOutput("sync pulp_in", pulp_gpio_in_o, 8'h3C);
    checkOutput("sync ps_in", ps_gpio_in_o, 8'h3C);

    // Two-cycle glitch on bit 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3D);
    highCount = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) pad_in_i = 8'h3C;
      tick();
      if (pulp_gpio_in_o[0] && ps_gpio_in_o[0]) highCount++;
    end
    checkOutput("glitch bit0 cycles", highCount, FILTER_ON ? 0 : 2);
    checkOutput("glitch settled", pulp_gpio_in_o, 8'h3C);

    // Reset while PS owns and drives everything.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 8'h0F, 8'h5A, 8'hFF, 8'h3C);
    tick();
    checkOutput("rstmid ps_gnt", ps_gnt_o, 1);
    tick();
    checkOutput("rstmid pad_dir driven", pad_dir_o, 8'hFF);
    rst_ni = 1'b0;
    tick();
    checkOutput("rstmid ps_gnt low", ps_gnt_o, 0);
    checkOutput("rstmid pad_dir off", pad_dir_o, 8'h00);
    checkOutput("rstmid owner", owner_o, 0);
    rst_ni = 1'b1;
    tick();
    checkOutput("rstmid regrant", ps_gnt_o, 1);
    checkOutput("rstmid regrant pads off", pad_dir_o, 8'h00);
    tick();
    checkOutput("rstmid regrant pads", pad_dir_o, 8'hFF);

    // Randomized run against the reference model.
    rReq = 1'b0; sReqR = 1'b0; rPad = 8'h00;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(4, 0) == 0) rReq = ~rReq;
      if ($urandom_range(4, 0) == 0) sReqR = ~sReqR;
      case ($urandom_range(7, 0))
        0:       rPad = 8'($urandom);
        1, 2:    rPad = rPad ^ (8'h01 << $urandom_range(7, 0));
        default: rPad = rPad;
      endcase
      rRst = (cyc == 0) ? 1'b0 : ($urandom_range(99, 0) != 0);
      applyStimulus(rRst, rReq, sReqR, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), rPad);
      modelEdge();
      tick();
      expIn = FILTER_ON ? mFilt : mHist[SYNC_STAGES-1];
      checkOutput($sformatf("rand%0d pulp_gnt", cyc), pulp_gnt_o, (mOwner == 1));
      checkOutput($sformatf("rand%0d ps_gnt", cyc), ps_gnt_o, (mOwner == 2));
      checkOutput($sformatf("rand%0d owner", cyc), owner_o, mOwner);
      checkOutput($sformatf("rand%0d pad_out", cyc), pad_out_o, mPadOut);
      checkOutput($sformatf("rand%0d pad_dir", cyc), pad_dir_o, mPadDir);
      checkOutput($sformatf("rand%0d pulp_in", cyc), pulp_gpio_in_o, expIn);
      checkOutput($sformatf("rand%0d ps_in", cyc), ps_gpio_in_o, expIn);
      checkOutput($sformatf("rand%0d dual_gnt", cyc), pulp_gnt_o & ps_gnt_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
